// File: rtl/sorted_list.sv
// Ordered-set store: elements are kept sorted at all times, so inserts and removals shift
// the register array in one cycle, while SUM walks the occupied slots one element per cycle.
module sorted_list #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LENGTH     = 8,
  parameter  int ORDER      = 0,
  parameter  int ALLOW_DUP  = 1,
  localparam int LW         = $clog2(LENGTH),
  localparam int CW         = $clog2(LENGTH + 1),
  localparam int OW         = LW + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op_sel,
  input  logic                  op_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LW-1:0]         index_in,
  output logic                  op_ready,
  output logic [OW-1:0]         data_out,
  output logic                  op_done,
  output logic                  op_error,
  output logic [1:0]            err_code,
  output logic [CW-1:0]         len,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_READ, OP_INSERT, OP_DEL_IDX, OP_DEL_VAL, OP_FIND, OP_SUM, OP_POP_FRONT, OP_POP_BACK
  } op_t;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_FULL  = 2'b01;
  localparam logic [1:0] E_RANGE = 2'b10;
  localparam logic [1:0] E_MISS  = 2'b11;

  state_t                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_mem [LENGTH];
  logic [CW-1:0]         r_len;
  logic [OW-1:0]         r_data_out;
  logic [OW-1:0]         r_acc;
  logic [1:0]            r_err;
  logic [LW-1:0]         r_ptr;

  logic                  w_accept, w_found, w_ins, w_del, w_start_sum;
  logic [CW-1:0]         w_pos;
  logic [LW-1:0]         w_match_idx, w_del_idx, w_last_idx;
  logic [OW-1:0]         w_result, w_sum_next;
  logic [1:0]            w_err;
  logic [DATA_WIDTH-1:0] w_ins_mem [LENGTH];
  logic [DATA_WIDTH-1:0] w_del_mem [LENGTH];

  assign w_accept   = op_en && (r_state == S_IDLE);
  assign w_last_idx = LW'(r_len - CW'(1));
  assign w_sum_next = r_acc + OW'(r_mem[r_ptr]);

  // Insert position lands after existing equals; descending scan leaves the lowest match.
  always_comb begin
    w_pos       = '0;
    w_found     = 1'b0;
    w_match_idx = '0;
    for (int i = LENGTH - 1; i >= 0; i--) begin
      if (CW'(i) < r_len) begin
        if ((ORDER != 0) ? (r_mem[i] >= data_in) : (r_mem[i] <= data_in))
          w_pos = w_pos + CW'(1);
        if (r_mem[i] == data_in) begin
          w_found     = 1'b1;
          w_match_idx = LW'(i);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_err       = E_OK;
    w_result    = r_data_out;
    w_ins       = 1'b0;
    w_del       = 1'b0;
    w_del_idx   = '0;
    w_start_sum = 1'b0;
    case (op_t'(op_sel))
      OP_READ: begin
        if (CW'(index_in) >= r_len) w_err = E_RANGE;
        else                        w_result = OW'(r_mem[index_in]);
      end
      OP_INSERT: begin
        if (full)                           w_err = E_FULL;
        else if (ALLOW_DUP == 0 && w_found) w_err = E_MISS;
        else begin
          w_ins    = 1'b1;
          w_result = OW'(w_pos);
        end
      end
      OP_DEL_IDX: begin
        if (CW'(index_in) >= r_len) w_err = E_RANGE;
        else begin
          w_del     = 1'b1;
          w_del_idx = index_in;
          w_result  = OW'(r_mem[index_in]);
        end
      end
      OP_DEL_VAL: begin
        if (!w_found) w_err = E_MISS;
        else begin
          w_del     = 1'b1;
          w_del_idx = w_match_idx;
          w_result  = OW'(w_match_idx);
        end
      end
      OP_FIND: begin
        if (!w_found) w_err = E_MISS;
        else          w_result = OW'(w_match_idx);
      end
      OP_SUM: begin
        if (empty) w_result = '0;
        else       w_start_sum = 1'b1;
      end
      OP_POP_FRONT: begin
        if (empty) w_err = E_RANGE;
        else begin
          w_del    = 1'b1;
          w_result = OW'(r_mem[0]);
        end
      end
      OP_POP_BACK: begin
        if (empty) w_err = E_RANGE;
        else begin
          w_del     = 1'b1;
          w_del_idx = w_last_idx;
          w_result  = OW'(r_mem[w_last_idx]);
        end
      end
      default: w_err = E_OK;
    endcase
  end

  // Shifted images of the array; slots beyond len are zero, so shifting pulls zeros in.
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      if (CW'(i) < w_pos)       w_ins_mem[i] = r_mem[i];
      else if (CW'(i) == w_pos) w_ins_mem[i] = data_in;
      else                      w_ins_mem[i] = r_mem[(i > 0) ? i - 1 : 0];
      if (LW'(i) < w_del_idx)   w_del_mem[i] = r_mem[i];
      else if (i < LENGTH - 1)  w_del_mem[i] = r_mem[(i < LENGTH - 1) ? i + 1 : i];
      else                      w_del_mem[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_start_sum ? S_SUM : S_DONE;
      S_SUM:   if (r_ptr == w_last_idx) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (r_state == S_IDLE);
    op_done  = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset element by element because vacant slots must always read zero.
      for (int i = 0; i < LENGTH; i++) r_mem[i] <= '0;
      r_len      <= '0;
      r_data_out <= '0;
      r_err      <= E_OK;
      r_acc      <= '0;
      r_ptr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start_sum) begin
              r_acc <= '0;
              r_ptr <= '0;
            end else begin
              r_data_out <= w_result;
              r_err      <= w_err;
              if (w_ins) begin
                r_mem <= w_ins_mem;
                r_len <= r_len + CW'(1);
              end
              if (w_del) begin
                r_mem <= w_del_mem;
                r_len <= r_len - CW'(1);
              end
            end
          end
        end
        S_SUM: begin
          r_acc <= w_sum_next;
          r_ptr <= r_ptr + LW'(1);
          if (r_ptr == w_last_idx) begin
            r_data_out <= w_sum_next;
            r_err      <= E_OK;
          end
        end
        S_DONE:  r_err <= E_OK;
        default: r_err <= E_OK;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign err_code = r_err;
  assign op_error = |r_err;
  assign len      = r_len;
  assign full     = (r_len == CW'(LENGTH));
  assign empty    = (r_len == '0);

endmodule

// File: tb/tb_sorted_list.sv
// Scoreboard bench for sorted_list: one ascending/duplicate-tolerant instance and one
// descending/duplicate-rejecting instance sharing stimulus, selected by use_b.
`timescale 1ns/1ps
module tb_sorted_list;
  localparam int DW = 8, LEN = 4, LW = 2, CW = 3, OW = 10;

  typedef enum logic [2:0] {
    READ, INSERT, DEL_IDX, DEL_VAL, FIND, SUM, POP_FRONT, POP_BACK
  } op_e;
  typedef struct {
    logic [OW-1:0] data;
    logic [1:0]    err;
    logic [CW-1:0] len;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;

  logic          clk = 1'b0, rst = 1'b1, op_en = 1'b0, use_b = 1'b0;
  logic [2:0]    op_sel = '0;
  logic [DW-1:0] data_in = '0;
  logic [LW-1:0] index_in = '0;

  logic a_ready, a_done, a_error, a_full, a_empty, b_ready, b_done, b_error, b_full, b_empty;
  logic [OW-1:0] a_data, b_data;
  logic [1:0]    a_err, b_err;
  logic [CW-1:0] a_len, b_len;

  logic          op_ready, op_done, op_error, full, empty;
  logic [OW-1:0] data_out;
  logic [1:0]    err_code;
  logic [CW-1:0] len;

  always #5 clk = ~clk;

  sorted_list #(.DATA_WIDTH(DW), .LENGTH(LEN), .ORDER(0), .ALLOW_DUP(1)) dut_a (
    .clk(clk), .rst(rst), .op_sel(op_sel), .op_en(op_en && !use_b), .data_in(data_in),
    .index_in(index_in), .op_ready(a_ready), .data_out(a_data), .op_done(a_done),
    .op_error(a_error), .err_code(a_err), .len(a_len), .full(a_full), .empty(a_empty));

  sorted_list #(.DATA_WIDTH(DW), .LENGTH(LEN), .ORDER(1), .ALLOW_DUP(0)) dut_b (
    .clk(clk), .rst(rst), .op_sel(op_sel), .op_en(op_en && use_b), .data_in(data_in),
    .index_in(index_in), .op_ready(b_ready), .data_out(b_data), .op_done(b_done),
    .op_error(b_error), .err_code(b_err), .len(b_len), .full(b_full), .empty(b_empty));

  assign op_ready = use_b ? b_ready : a_ready;
  assign op_done  = use_b ? b_done  : a_done;
  assign op_error = use_b ? b_error : a_error;
  assign full     = use_b ? b_full  : a_full;
  assign empty    = use_b ? b_empty : a_empty;
  assign data_out = use_b ? b_data  : a_data;
  assign err_code = use_b ? b_err   : a_err;
  assign len      = use_b ? b_len   : a_len;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op from a negedge; results are sampled at the negedge where op_done is seen.
  // lat = edges after the accept edge at which op_done appeared; busy = negedges with op_ready low.
  task automatic issue(input op_e op, input logic [DW-1:0] d, input logic [LW-1:0] idx,
                       output logic [OW-1:0] rdata, output logic [1:0] rerr, output logic rerror,
                       output logic [CW-1:0] rlen, output int lat, output int busy);
    int w;
    op_sel = op; data_in = d; index_in = idx; op_en = 1'b1;
    w = 0;
    while (!op_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    op_en = 1'b0;
    lat = 0;
    while (!op_done && lat < 50) begin @(negedge clk); lat++; end
    rdata = data_out; rerr = err_code; rerror = op_error; rlen = len;
    busy = lat + 1;
    @(negedge clk);
    while (!op_ready && busy < 60) begin busy++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      use_b = (k == 1);
      #1;
      n_vec++;
      if ({len, empty, full, op_ready, op_done, op_error, err_code, data_out} !==
          {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 10'd0}) begin
        n_bad++;
        $display("FAIL reset[%0d]: len=%0d empty=%b full=%b ready=%b done=%b error=%b err=%0d data=%0d, want 0 1 0 1 0 0 0 0",
                 k, len, empty, full, op_ready, op_done, op_error, err_code, data_out);
      end
    end
    use_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_insert();
    op_e           ops[9] = '{INSERT, INSERT, INSERT, INSERT, INSERT, READ, READ, READ, READ};
    logic [DW-1:0] din[9] = '{30, 10, 20, 10, 40, 0, 0, 0, 0};
    logic [LW-1:0] ix[9]  = '{0, 0, 0, 0, 0, 0, 1, 2, 3};
    int            ed[9]  = '{0, 0, 1, 1, 1, 10, 10, 20, 30};
    logic [1:0]    ee[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int            el[9]  = '{1, 2, 3, 4, 4, 4, 4, 4, 4};
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy; exp_t e;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{data: OW'(ed[i]), err: ee[i], len: CW'(el[i]), lat: 0});
      issue(ops[i], din[i], ix[i], rd, re, rf, rl, lat, busy);
      e = sb.pop_front();
      n_vec++;
      if ({rd, re, rf, rl, lat} !== {e.data, e.err, (e.err != 2'b00), e.len, e.lat}) begin
        n_bad++;
        $display("FAIL insert[%0d]: data=%0d err=%0d error=%b len=%0d lat=%0d, want data=%0d err=%0d len=%0d lat=%0d",
                 i, rd, re, rf, rl, lat, e.data, e.err, e.len, e.lat);
      end
      if (i == 3) begin
        n_vec++;
        if (full !== 1'b1) begin
          n_bad++;
          $display("FAIL full_flag: full=%b, want 1", full);
        end
      end
    end
  endtask

  task automatic test_sum();
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy; exp_t e;
    sb.push_back('{data: OW'(70), err: 2'b00, len: CW'(4), lat: 4});
    issue(SUM, 0, 0, rd, re, rf, rl, lat, busy);
    e = sb.pop_front();
    n_vec++;
    if ({rd, re, rf, rl, lat} !== {e.data, e.err, (e.err != 2'b00), e.len, e.lat}) begin
      n_bad++;
      $display("FAIL sum: data=%0d err=%0d error=%b len=%0d lat=%0d, want data=%0d err=%0d len=%0d lat=%0d",
               rd, re, rf, rl, lat, e.data, e.err, e.len, e.lat);
    end
    n_vec++;
    if (busy !== 5) begin
      n_bad++;
      $display("FAIL sum_busy: op_ready low for %0d cycles, want 5", busy);
    end
  endtask

  task automatic test_find();
    logic [DW-1:0] din[3] = '{20, 25, 10};
    int            ed[3]  = '{2, 2, 0};
    logic [1:0]    ee[3]  = '{0, 3, 0};
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{data: OW'(ed[i]), err: ee[i], len: CW'(4), lat: 0});
      issue(FIND, din[i], 0, rd, re, rf, rl, lat, busy);
      e = sb.pop_front();
      n_vec++;
      if ({rd, re, rf, rl, lat} !== {e.data, e.err, (e.err != 2'b00), e.len, e.lat}) begin
        n_bad++;
        $display("FAIL find[%0d]: data=%0d err=%0d error=%b len=%0d lat=%0d, want data=%0d err=%0d len=%0d lat=%0d",
                 i, rd, re, rf, rl, lat, e.data, e.err, e.len, e.lat);
      end
    end
  endtask

  task automatic test_pop_delete();
    op_e ops[10] = '{POP_FRONT, READ, POP_BACK, DEL_VAL, READ, DEL_VAL, DEL_IDX, DEL_IDX, POP_FRONT, SUM};
    logic [DW-1:0] din[10] = '{0, 0, 0, 10, 0, 99, 0, 0, 0, 0};
    logic [LW-1:0] ix[10]  = '{0, 3, 0, 0, 0, 0, 1, 0, 0, 0};
    int            ed[10]  = '{10, 10, 30, 0, 20, 20, 20, 20, 20, 0};
    logic [1:0]    ee[10]  = '{0, 2, 0, 0, 0, 3, 2, 0, 2, 0};
    int            el[10]  = '{3, 3, 2, 1, 1, 1, 1, 0, 0, 0};
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy; exp_t e;
    logic [DW-1:0] slots;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{data: OW'(ed[i]), err: ee[i], len: CW'(el[i]), lat: 0});
      issue(ops[i], din[i], ix[i], rd, re, rf, rl, lat, busy);
      e = sb.pop_front();
      n_vec++;
      if ({rd, re, rf, rl, lat} !== {e.data, e.err, (e.err != 2'b00), e.len, e.lat}) begin
        n_bad++;
        $display("FAIL pop_del[%0d]: data=%0d err=%0d error=%b len=%0d lat=%0d, want data=%0d err=%0d len=%0d lat=%0d",
                 i, rd, re, rf, rl, lat, e.data, e.err, e.len, e.lat);
      end
      if (i == 4) begin
        slots = dut_a.r_mem[1] | dut_a.r_mem[2] | dut_a.r_mem[3];
        n_vec++;
        if (slots !== 8'd0) begin
          n_bad++;
          $display("FAIL vacant_slots: OR of slots 1..3 = %0d, want 0", slots);
        end
      end
    end
  endtask

  task automatic test_dup_desc();
    op_e ops[8] = '{INSERT, INSERT, INSERT, READ, READ, POP_FRONT, POP_FRONT, POP_FRONT};
    logic [DW-1:0] din[8] = '{5, 9, 5, 0, 0, 0, 0, 0};
    logic [LW-1:0] ix[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    int            ed[8]  = '{0, 0, 0, 9, 5, 9, 5, 5};
    logic [1:0]    ee[8]  = '{0, 0, 3, 0, 0, 0, 0, 2};
    int            el[8]  = '{1, 2, 2, 2, 2, 1, 0, 0};
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy; exp_t e;
    use_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{data: OW'(ed[i]), err: ee[i], len: CW'(el[i]), lat: 0});
      issue(ops[i], din[i], ix[i], rd, re, rf, rl, lat, busy);
      e = sb.pop_front();
      n_vec++;
      if ({rd, re, rf, rl, lat} !== {e.data, e.err, (e.err != 2'b00), e.len, e.lat}) begin
        n_bad++;
        $display("FAIL dup_desc[%0d]: data=%0d err=%0d error=%b len=%0d lat=%0d, want data=%0d err=%0d len=%0d lat=%0d",
                 i, rd, re, rf, rl, lat, e.data, e.err, e.len, e.lat);
      end
    end
    use_b = 1'b0;
  endtask

  // Holds op_en with an INSERT request through a SUM; the request must not be taken.
  task automatic test_busy_ignored();
    logic [OW-1:0] rd; logic [1:0] re; logic rf; logic [CW-1:0] rl; int lat, busy;
    issue(INSERT, 5, 0, rd, re, rf, rl, lat, busy);
    issue(INSERT, 7, 0, rd, re, rf, rl, lat, busy);
    op_sel = SUM; op_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_sel = INSERT; data_in = 99;
    lat = 0;
    while (!op_done && lat < 50) begin @(negedge clk); lat++; end
    op_en = 1'b0;
    n_vec++;
    if ({data_out, op_error, lat} !== {10'd12, 1'b0, 32'd2}) begin
      n_bad++;
      $display("FAIL busy_sum: data=%0d error=%b lat=%0d, want data=12 error=0 lat=2", data_out, op_error, lat);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({len, op_done, op_ready} !== {3'd2, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL busy_ignored: len=%0d done=%b ready=%b, want len=2 done=0 ready=1", len, op_done, op_ready);
    end
    issue(READ, 0, 1, rd, re, rf, rl, lat, busy);
    n_vec++;
    if ({rd, re} !== {10'd7, 2'b00}) begin
      n_bad++;
      $display("FAIL busy_contents: read[1]=%0d err=%0d, want 7 err=0", rd, re);
    end
  endtask

  task automatic test_reset_mid_sum();
    op_sel = SUM; op_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({len, op_ready, op_done, data_out} !== {3'd0, 1'b1, 1'b0, 10'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_sum: len=%0d ready=%b done=%b data=%0d, want len=0 ready=1 done=0 data=0",
               len, op_ready, op_done, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_sum();
    test_find();
    test_pop_delete();
    test_dup_desc();
    test_busy_ignored();
    test_reset_mid_sum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
